// File: rtl/game_pkg.sv
// Shared types and defaults for the game input conditioning logic.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        CONFLICT = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    localparam int DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/game_input_ctrl_if.sv
// Button inputs, move enable and conditioned move outputs between the board and the game.
interface game_input_ctrl_if;
    logic       btn_n;
    logic       btn_s;
    logic       btn_e;
    logic       btn_w;
    logic       en;
    logic       n;
    logic       s;
    logic       e;
    logic       w;
    logic [7:0] moves;

    modport master (
        output btn_n, btn_s, btn_e, btn_w, en,
        input  n, s, e, w, moves
    );

    modport slave (
        input  btn_n, btn_s, btn_e, btn_w, en,
        output n, s, e, w, moves
    );
endinterface

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a stable-count debouncer.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        deb_d   = deb_q;
        cnt_d   = '0;
        cnt_inc = cnt_q + CNT_W'(1);
        if (sync2_q != deb_q) begin
            // The level flips on the cycle the count would reach the threshold.
            if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb = deb_q;
endmodule

// File: rtl/game_input_ctrl.sv
// Turns four debounced direction buttons into single-cycle move pulses and a saturating move count.
module game_input_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    game_input_ctrl_if.slave  bus
);
    logic [3:0]  deb;
    logic        single;
    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic [3:0]  pulse_q;
    logic [3:0]  pulse_d;
    logic [7:0]  moves_q;
    logic [7:0]  moves_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_n (
        .clk(clk), .reset(reset), .raw(bus.btn_n), .deb(deb[DIR_N])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s (
        .clk(clk), .reset(reset), .raw(bus.btn_s), .deb(deb[DIR_S])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_e (
        .clk(clk), .reset(reset), .raw(bus.btn_e), .deb(deb[DIR_E])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_w (
        .clk(clk), .reset(reset), .raw(bus.btn_w), .deb(deb[DIR_W])
    );

    assign single = (deb != 4'b0000) && ((deb & (deb - 4'd1)) == 4'b0000);

    always_comb begin
        state_d = state_q;
        pulse_d = 4'b0000;
        moves_d = moves_q;
        case (state_q)
            IDLE: begin
                if (single) begin
                    // A press seen while disabled is consumed, never replayed.
                    state_d = HELD;
                    if (bus.en) begin
                        pulse_d = deb;
                        moves_d = (moves_q != 8'hFF) ? moves_q + 8'd1 : moves_q;
                    end
                end else if (deb != 4'b0000) begin
                    state_d = CONFLICT;
                end
            end
            HELD, CONFLICT: begin
                if (deb == 4'b0000) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pulse_q <= 4'b0000;
            moves_q <= 8'd0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            moves_q <= moves_d;
        end
    end

    assign bus.n     = pulse_q[DIR_N];
    assign bus.s     = pulse_q[DIR_S];
    assign bus.e     = pulse_q[DIR_E];
    assign bus.w     = pulse_q[DIR_W];
    assign bus.moves = moves_q;
endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed bench for game_input_ctrl with a scoreboard of expected move pulses.
module tb_game_input_ctrl;
    import game_pkg::*;

    localparam int D = 4;

    typedef struct {
        int dir;
        int cyc;
        int moves;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_moves = 0;
    exp_t q[$];
    exp_t mon_e;
    logic [3:0] mon_pulse;

    game_input_ctrl_if bus();

    game_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_btn(input int dir, input logic v);
        case (dir)
            0: bus.btn_n = v;
            1: bus.btn_s = v;
            2: bus.btn_e = v;
            default: bus.btn_w = v;
        endcase
    endtask

    // Called at the negedge where the button goes high: edge 0 is the next posedge.
    task automatic expect_move(input int dir);
        exp_t x;
        exp_moves = (exp_moves < 255) ? exp_moves + 1 : 255;
        x.dir = dir;
        x.cyc = cyc + D + 3;
        x.moves = exp_moves;
        q.push_back(x);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pending"}, q.size(), 0);
        check({tag, "_moves"}, int'(bus.moves), exp_moves);
    endtask

    always @(negedge clk) begin
        mon_pulse = {bus.w, bus.e, bus.s, bus.n};
        if (mon_pulse != 4'b0000) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", int'(mon_pulse), 0);
            end else begin
                mon_e = q.pop_front();
                check("pulse_dir", int'(mon_pulse), 1 << mon_e.dir);
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_moves", int'(bus.moves), mon_e.moves);
            end
        end
    end

    initial begin
        bus.btn_n = 1'b0;
        bus.btn_s = 1'b0;
        bus.btn_e = 1'b0;
        bus.btn_w = 1'b0;
        bus.en    = 1'b1;

        // Reset state
        wait_cycles(3);
        check("rst_pulses", int'({bus.w, bus.e, bus.s, bus.n}), 0);
        check("rst_moves", int'(bus.moves), 0);
        rst_n = 1'b1;
        wait_cycles(3);

        // Single press
        set_btn(DIR_N, 1'b1);
        expect_move(DIR_N);
        wait_cycles(20);
        set_btn(DIR_N, 1'b0);
        wait_cycles(15);
        check_idle("single");

        // Glitch shorter than the debounce window
        set_btn(DIR_E, 1'b1);
        wait_cycles(3);
        set_btn(DIR_E, 1'b0);
        wait_cycles(15);
        check_idle("glitch");

        // Conflict, then a clean press
        set_btn(DIR_N, 1'b1);
        set_btn(DIR_E, 1'b1);
        wait_cycles(20);
        set_btn(DIR_N, 1'b0);
        set_btn(DIR_E, 1'b0);
        wait_cycles(10);
        check_idle("conflict");
        set_btn(DIR_E, 1'b1);
        expect_move(DIR_E);
        wait_cycles(20);
        set_btn(DIR_E, 1'b0);
        wait_cycles(15);
        check_idle("after_conflict");

        // Second button while held
        set_btn(DIR_S, 1'b1);
        expect_move(DIR_S);
        wait_cycles(10);
        set_btn(DIR_W, 1'b1);
        wait_cycles(20);
        set_btn(DIR_S, 1'b0);
        set_btn(DIR_W, 1'b0);
        wait_cycles(15);
        check_idle("held_second");
        set_btn(DIR_W, 1'b1);
        expect_move(DIR_W);
        wait_cycles(20);
        set_btn(DIR_W, 1'b0);
        wait_cycles(15);
        check_idle("fresh_w");

        // Enable low: press consumed and not replayed
        bus.en = 1'b0;
        set_btn(DIR_N, 1'b1);
        wait_cycles(15);
        set_btn(DIR_N, 1'b0);
        wait_cycles(15);
        bus.en = 1'b1;
        wait_cycles(20);
        check_idle("en_low");

        // Reset mid-debounce, button held through release
        set_btn(DIR_N, 1'b1);
        wait_cycles(2);
        rst_n = 1'b0;
        #1;
        check("midrst_pulses", int'({bus.w, bus.e, bus.s, bus.n}), 0);
        check("midrst_moves", int'(bus.moves), 0);
        q.delete();
        exp_moves = 0;
        wait_cycles(3);
        rst_n = 1'b1;
        expect_move(DIR_N);
        wait_cycles(20);
        set_btn(DIR_N, 1'b0);
        wait_cycles(15);
        check_idle("post_reset");

        // Saturation over 260 separate presses
        for (int i = 0; i < 260; i++) begin
            set_btn(i % 4, 1'b1);
            expect_move(i % 4);
            wait_cycles(D + 10);
            set_btn(i % 4, 1'b0);
            wait_cycles(D + 10);
        end
        wait_cycles(10);
        check_idle("saturate");
        check("sat_value", int'(bus.moves), 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/game_input_ctrl.md
# game_input_ctrl

Conditions the four raw direction push-buttons into clean, single-cycle `n`/`s`/`e`/`w` move pulses for the `game` top. It synchronises, debounces, and arbitrates the buttons. Each distinct press produces exactly one move, and conflicting presses produce none. The block also suppresses moves while the game is over and keeps a saturating count of issued moves for display.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a debounced level changes; legal range 1..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of each debounce counter; derived, not overridden.
- `clk`  in  1  system clock; all flops on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_n`, `btn_s`, `btn_e`, `btn_w`  in  1 each  raw, asynchronous, bouncing buttons; high = pressed.
- `en`  in  1  move enable; top connects `~(win | d)`.
- `n`, `s`, `e`, `w`  out  1 each  registered one-cycle move pulses to `game`; at most one high in any cycle.
- `moves`  out  8  registered count of issued moves; saturates at 255.

## Operation
- **Per-button path.** Each button has its own path:
  - 2-flop synchroniser produces `sync`.
  - Debouncer holds a debounced level `deb` and a counter `cnt`.
  - When `sync == deb`, `cnt` is cleared to 0.
  - When `sync != deb`, `cnt` increments. On the cycle `cnt` would reach `DEBOUNCE_CYCLES`, `deb` toggles and `cnt` clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `deb`.
- **Arbiter FSM.** States are `IDLE`, `HELD`, `CONFLICT`.
  - `IDLE`, all `deb` low: stay.
  - `IDLE`, exactly one `deb` high and `en`=1: assert the matching pulse next cycle, increment `moves`, go to `HELD`.
  - `IDLE`, exactly one `deb` high and `en`=0: no pulse, go to `HELD`. The press is consumed and is not replayed when `en` rises.
  - `IDLE`, two or more `deb` high: no pulse, go to `CONFLICT`.
  - `HELD` or `CONFLICT`: no pulses. Return to `IDLE` only when all four `deb` are low.
- **Pressing while held.** A second button pressed while in `HELD` never generates a move. A move needs release of all buttons, then a fresh single press.
- **Move counter.** `moves` increments by 1 with every pulse. At 255 it holds.
- **Reset.** While `reset`=0, all of the following are 0 and the FSM is in `IDLE`:
  - sync flops, `deb`, `cnt`
  - `n`, `s`, `e`, `w`
  - `moves`

  A button still held when reset releases is treated as a new press after the normal debounce latency.

## Timing
- **Press latency.** Take edge 0 as the first edge at which `sync1` samples a stable press.
  - `sync` rises after edge 1.
  - `cnt` counts at edges 2..D+1, and `deb` rises at edge D+1.
  - The pulse is high for exactly the cycle after edge D+2.
  - `moves` updates at the same edge as the pulse.
- **Release latency.** Symmetric: `deb` falls D+1 edges after the release is first sampled. The FSM leaves `HELD`/`CONFLICT` at the following edge.
- **Minimum move spacing.** Fresh single presses produce moves no closer than 2·D+4 cycles apart.
- **`en` timing.** `en` is sampled in the same cycle the FSM evaluates `IDLE`. No combinational path exists from any input to any output.

## Structure
- **Package `game_pkg`** holds:
  - `ctrl_state_t`, an enum of `IDLE`, `HELD`, `CONFLICT`.
  - `dir_t`, an enum of `DIR_N`, `DIR_S`, `DIR_E`, `DIR_W`.
  - `DEBOUNCE_DEFAULT = 16`.
- **Sub-module `btn_debounce`** holds the synchroniser, `cnt` and `deb` for one button, with parameter `DEBOUNCE_CYCLES` and ports `clk`, `reset`, `raw`, `deb`. It is instantiated four times.
- **Top of this block** holds the arbiter FSM, the pulse registers and the counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `en`=1 unless stated.
- **Single press.** Hold `btn_n` high for 20 cycles from edge 0 → `n` high only in the cycle after edge 6; `moves` 0→1; `s`/`e`/`w` stay 0.
- **Glitch.** Pulse `btn_e` high for 3 cycles, then low → no pulse, `moves` stays 0.
- **Conflict, then clean press.**
  - Raise `btn_n` and `btn_e` on the same cycle and hold both for 20 cycles → no pulse.
  - Release both, wait 10 cycles, then press `btn_e` alone → one `e` pulse; `moves`=1.
- **Second button while held.** Hold `btn_s`, and 10 cycles later also press `btn_w` → exactly one `s` pulse and no `w`. Release both, then press `btn_w` alone → one `w` pulse.
- **Enable low.** With `en`=0, press and release `btn_n` → no pulse, `moves` unchanged. Raise `en` while no button is pressed → still no pulse.
- **Reset and saturation.**
  - Assert `reset` low 2 cycles into a debounce → all outputs 0 immediately. Keep `btn_n` held through reset release → `n` pulse D+2 edges after release.
  - Issue 260 separate presses → `moves` stops at 255.
